// File: rtl/bus_dma_m.sv
// Bus-mastering block copier: halts the 6502 through RDY and copies bytes from src to dst.
// Optional BUS_DMA_FILL_EN adds a fill mode that writes a constant byte instead of copying.
module bus_dma_m #(
  parameter int LENGTH_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             src_address,
  input  logic [15:0]             dst_address,
  input  logic [LENGTH_WIDTH-1:0] length,
`ifdef BUS_DMA_FILL_EN
  input  logic                    fill,
  input  logic [7:0]              fill_value,
`endif
  input  logic [7:0]              bus_data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    cpu_rdy,
  output logic [15:0]             bus_address,
  output logic [7:0]              bus_data_out,
  output logic                    bus_write
);

  typedef enum logic [2:0] {IDLE, HALT, READ, CAPTURE, WRITE, DONE} state_e;

  state_e                state_q, state_d;
  logic [15:0]           src_q, src_d;
  logic [15:0]           dst_q, dst_d;
  logic [LENGTH_WIDTH:0] count_q, count_d;
  logic [7:0]            data_q, data_d;
  logic                  fill_mode;

  localparam logic [LENGTH_WIDTH:0] CountOne  = (LENGTH_WIDTH+1)'(1);
  localparam logic [LENGTH_WIDTH:0] CountFull = {1'b1, {LENGTH_WIDTH{1'b0}}};

`ifdef BUS_DMA_FILL_EN
  logic fill_q, fill_d;
  assign fill_mode = fill_q;
`else
  assign fill_mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
`ifdef BUS_DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      data_q  <= data_d;
`ifdef BUS_DMA_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  // Fill mode preloads the data register so WRITE needs no separate source select.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    data_d  = data_q;
`ifdef BUS_DMA_FILL_EN
    fill_d  = fill_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_address;
          dst_d   = dst_address;
          count_d = (length == '0) ? CountFull : {1'b0, length};
`ifdef BUS_DMA_FILL_EN
          fill_d  = fill;
          if (fill) data_d = fill_value;
`endif
        end
      end
      CAPTURE: data_d = bus_data_in;
      WRITE: begin
        src_d   = src_q + 16'd1;
        dst_d   = dst_q + 16'd1;
        count_d = count_q - CountOne;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HALT;
      HALT:    state_d = fill_mode ? WRITE : READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE: begin
        if (count_q == CountOne) state_d = DONE;
        else                     state_d = fill_mode ? WRITE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b1;
    cpu_rdy      = 1'b0;
    done         = 1'b0;
    bus_write    = 1'b0;
    bus_address  = 16'h0000;
    bus_data_out = 8'h00;
    case (state_q)
      IDLE: begin
        busy    = 1'b0;
        cpu_rdy = 1'b1;
      end
      READ, CAPTURE: bus_address = src_q;
      WRITE: begin
        bus_address  = dst_q;
        bus_data_out = data_q;
        bus_write    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_dma_m.sv
// Self-checking bench for bus_dma_m: scoreboard of expected bus writes plus done/RDY timing checks.
// Build with +define+BUS_DMA_FILL_EN to also exercise the fill mode.
module tb_bus_dma_m;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] srcAddr = '0;
  logic [15:0] dstAddr = '0;
  logic [7:0]  len = '0;
  logic [7:0]  busDataIn = '0;
  logic        busy, done, cpuRdy, busWrite;
  logic [15:0] busAddress;
  logic [7:0]  busDataOut;
`ifdef BUS_DMA_FILL_EN
  logic        fillIn = 1'b0;
  logic [7:0]  fillValue = '0;
`endif

  logic [7:0] srcMem [0:65535];
  wr_t        expQ[$];
  wr_t        obsQ[$];
  int         doneQ[$];
  int         cyc = 0;
  int         startCyc = 0;
  int         rdyLow = 0;
  int         assertCount = 0;
  int         failCount = 0;

  bus_dma_m #(.LENGTH_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_address(srcAddr), .dst_address(dstAddr), .length(len),
`ifdef BUS_DMA_FILL_EN
    .fill(fillIn), .fill_value(fillValue),
`endif
    .bus_data_in(busDataIn), .busy(busy), .done(done), .cpu_rdy(cpuRdy),
    .bus_address(busAddress), .bus_data_out(busDataOut), .bus_write(busWrite)
  );

  always #5 clk = ~clk;

  // Responder model: read data appears the cycle after the address is presented.
  always @(posedge clk) begin
    busDataIn <= srcMem[busAddress];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (busWrite) obsQ.push_back('{busAddress, busDataOut});
    if (done) doneQ.push_back(cyc - startCyc + 1);
    if (!cpuRdy) rdyLow++;
  end

  task automatic pushCopy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++)
      expQ.push_back('{16'(d + 16'(i)), srcMem[16'(s + 16'(i))]});
  endtask

  task automatic runTransfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                             output bit timedOut);
    @(negedge clk);
    srcAddr = s; dstAddr = d; len = n; start = 1'b1;
    obsQ.delete(); doneQ.delete(); rdyLow = 0;
    @(negedge clk);
    start = 1'b0;
    startCyc = cyc;
    timedOut = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        timedOut = 1'b0;
        break;
      end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    assertCount++; if (cpuRdy !== 1'b1) begin failCount++; $display("[TB] FAIL reset_cpu_rdy: got %b, expected 1", cpuRdy); end
    assertCount++; if (busWrite !== 1'b0) begin failCount++; $display("[TB] FAIL reset_bus_write: got %b, expected 0", busWrite); end
    assertCount++; if (busAddress !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_bus_address: got %h, expected 0000", busAddress); end
    assertCount++; if (busDataOut !== 8'h00) begin failCount++; $display("[TB] FAIL reset_bus_data_out: got %h, expected 00", busDataOut); end
  endtask

  task automatic test_copy;
    bit to;
    wr_t e, o;
    pushCopy(16'h0200, 16'h4800, 4);
    runTransfer(16'h0200, 16'h4800, 8'd4, to);
    assertCount++; if (to) begin failCount++; $display("[TB] FAIL copy_timeout: busy still 1, expected 0"); end
    assertCount++; if (obsQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL copy_write_count: got %0d, expected %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertCount++; if (o !== e) begin failCount++; $display("[TB] FAIL copy_write: got %h/%h, expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete();
    assertCount++; if (doneQ.size() != 1) begin failCount++; $display("[TB] FAIL copy_done_count: got %0d, expected 1", doneQ.size()); end
    assertCount++; if (doneQ.size() > 0 && doneQ[0] != 14) begin failCount++; $display("[TB] FAIL copy_done_cycle: got %0d, expected 14", doneQ[0]); end
    assertCount++; if (rdyLow != 14) begin failCount++; $display("[TB] FAIL copy_rdy_low: got %0d, expected 14", rdyLow); end
  endtask

  task automatic test_wrap;
    bit to;
    wr_t e, o;
    expQ.push_back('{16'hFFFF, 8'h11});
    expQ.push_back('{16'h0000, 8'h22});
    expQ.push_back('{16'h0001, 8'h33});
    runTransfer(16'hFFFE, 16'hFFFF, 8'd3, to);
    assertCount++; if (to) begin failCount++; $display("[TB] FAIL wrap_timeout: busy still 1, expected 0"); end
    assertCount++; if (obsQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL wrap_write_count: got %0d, expected %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertCount++; if (o !== e) begin failCount++; $display("[TB] FAIL wrap_write: got %h/%h, expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete();
    assertCount++; if (doneQ.size() != 1 || doneQ[0] != 11) begin failCount++; $display("[TB] FAIL wrap_done: got %0d pulses, expected 1 at cycle 11", doneQ.size()); end
  endtask

  task automatic test_length_zero;
    bit to;
    wr_t e, o;
    pushCopy(16'h1000, 16'h3000, 256);
    runTransfer(16'h1000, 16'h3000, 8'd0, to);
    assertCount++; if (to) begin failCount++; $display("[TB] FAIL len0_timeout: busy still 1, expected 0"); end
    assertCount++; if (obsQ.size() != 256) begin failCount++; $display("[TB] FAIL len0_write_count: got %0d, expected 256", obsQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertCount++; if (o !== e) begin failCount++; $display("[TB] FAIL len0_write: got %h/%h, expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete();
    assertCount++; if (doneQ.size() != 1) begin failCount++; $display("[TB] FAIL len0_done_count: got %0d, expected 1", doneQ.size()); end
    assertCount++; if (doneQ.size() > 0 && doneQ[0] != 770) begin failCount++; $display("[TB] FAIL len0_done_cycle: got %0d, expected 770", doneQ[0]); end
  endtask

  task automatic test_back_to_back;
    bit to;
    wr_t e, o;
    pushCopy(16'h0300, 16'h5000, 3);
    @(negedge clk);
    srcAddr = 16'h0300; dstAddr = 16'h5000; len = 8'd3; start = 1'b1;
    obsQ.delete(); doneQ.delete(); rdyLow = 0;
    @(negedge clk);
    start = 1'b0;
    startCyc = cyc;
    repeat (3) @(negedge clk);
    srcAddr = 16'h0700; dstAddr = 16'h6000; len = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #1;
    assertCount++; if (to) begin failCount++; $display("[TB] FAIL b2b_timeout: busy still 1, expected 0"); end
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_restart: busy got %b, expected 0", busy); end
    assertCount++; if (obsQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL b2b_write_count: got %0d, expected %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertCount++; if (o !== e) begin failCount++; $display("[TB] FAIL b2b_write: got %h/%h, expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete();
    assertCount++; if (doneQ.size() != 1 || doneQ[0] != 11) begin failCount++; $display("[TB] FAIL b2b_done: got %0d pulses, expected 1 at cycle 11", doneQ.size()); end
  endtask

  task automatic test_reset_abort;
    bit to;
    int writesSeen = 0;
    wr_t e, o;
    @(negedge clk);
    srcAddr = 16'h0200; dstAddr = 16'h4800; len = 8'd4; start = 1'b1;
    obsQ.delete(); doneQ.delete();
    @(negedge clk);
    start = 1'b0;
    startCyc = cyc;
    for (int i = 0; i < 40; i++) begin
      if (busWrite) writesSeen++;
      if (writesSeen == 3) break;
      @(negedge clk);
    end
    assertCount++; if (writesSeen != 3) begin failCount++; $display("[TB] FAIL abort_third_write: got %0d writes, expected 3", writesSeen); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
    assertCount++; if (cpuRdy !== 1'b1) begin failCount++; $display("[TB] FAIL abort_cpu_rdy: got %b, expected 1", cpuRdy); end
    assertCount++; if (busAddress !== 16'h0000) begin failCount++; $display("[TB] FAIL abort_bus_address: got %h, expected 0000", busAddress); end
    repeat (20) @(negedge clk);
    #1;
    assertCount++; if (doneQ.size() != 0) begin failCount++; $display("[TB] FAIL abort_no_done: got %0d pulses, expected 0", doneQ.size()); end
    pushCopy(16'h0202, 16'h4900, 2);
    runTransfer(16'h0202, 16'h4900, 8'd2, to);
    assertCount++; if (to) begin failCount++; $display("[TB] FAIL abort_restart_timeout: busy still 1, expected 0"); end
    assertCount++; if (obsQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL abort_restart_count: got %0d, expected %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertCount++; if (o !== e) begin failCount++; $display("[TB] FAIL abort_restart_write: got %h/%h, expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete();
    assertCount++; if (doneQ.size() != 1 || doneQ[0] != 8) begin failCount++; $display("[TB] FAIL abort_restart_done: got %0d pulses, expected 1 at cycle 8", doneQ.size()); end
  endtask

`ifdef BUS_DMA_FILL_EN
  task automatic test_fill;
    bit to;
    wr_t e, o;
    for (int i = 0; i < 8; i++) expQ.push_back('{16'(16'h4000 + 16'(i)), 8'h00});
    fillIn = 1'b1; fillValue = 8'h00;
    runTransfer(16'h0200, 16'h4000, 8'd8, to);
    fillIn = 1'b0;
    assertCount++; if (to) begin failCount++; $display("[TB] FAIL fill_timeout: busy still 1, expected 0"); end
    assertCount++; if (obsQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL fill_write_count: got %0d, expected %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertCount++; if (o !== e) begin failCount++; $display("[TB] FAIL fill_write: got %h/%h, expected %h/%h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete();
    assertCount++; if (doneQ.size() != 1 || doneQ[0] != 10) begin failCount++; $display("[TB] FAIL fill_done: got %0d pulses, expected 1 at cycle 10", doneQ.size()); end
  endtask
`endif

  initial begin
    for (int a = 0; a < 65536; a++) srcMem[a] = 8'(a * 7 + 3);
    srcMem[16'h0200] = 8'hA0;
    srcMem[16'h0201] = 8'hA1;
    srcMem[16'h0202] = 8'hA2;
    srcMem[16'h0203] = 8'hA3;
    srcMem[16'hFFFE] = 8'h11;
    srcMem[16'hFFFF] = 8'h22;
    srcMem[16'h0000] = 8'h33;
    test_reset();
    test_copy();
    test_wrap();
    test_length_zero();
    test_back_to_back();
    test_reset_abort();
`ifdef BUS_DMA_FILL_EN
    test_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
